max_argmax_stream: RTL and testbench

Streaming, fully pipelined extremum finder for the lane datapath. It reduces NUM_LANES packed lanes per beat through a registered comparison tree, then accumulates across a multi-beat frame. Once per frame it reports the maximum (or minimum) value, its lane and beat position, and the frame length. It accepts one beat per cycle with no backpressure and sits downstream of the lane producers, feeding frame-level decision logic.

---
 rtl/max_argmax_stream_if.sv | 31 +++
 rtl/max_argmax_stream.sv | 196 +++++++++++++++++++
 tb/tb_max_argmax_stream.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/max_argmax_stream_if.sv
// Lane-beat stream in, per-frame extremum result out; master drives beats, slave is the reducer.
// No ready path: the producer pushes one beat per cycle and the result is a one-cycle pulse.
interface max_argmax_stream_if #(
    parameter int WIDTH      = 4,
    parameter int NUM_LANES  = 4,
    parameter int BEAT_CNT_W = 8
);
    localparam int LEVELS = $clog2(NUM_LANES);
    localparam int LANE_W = (LEVELS < 1) ? 1 : LEVELS;

    logic                         in_valid;
    logic                         in_last;
    logic                         mode_min;
    logic [NUM_LANES*WIDTH-1:0]   lane_values;

    logic                         out_valid;
    logic [WIDTH-1:0]             out_value;
    logic [LANE_W-1:0]            out_lane;
    logic [BEAT_CNT_W-1:0]        out_beat;
    logic [BEAT_CNT_W-1:0]        out_beats;

    modport master (
        output in_valid, in_last, mode_min, lane_values,
        input  out_valid, out_value, out_lane, out_beat, out_beats
    );

    modport slave (
        input  in_valid, in_last, mode_min, lane_values,
        output out_valid, out_value, out_lane, out_beat, out_beats
    );
endinterface

// File: rtl/max_argmax_stream.sv
// Per-frame max/min + argmax across lanes and beats; LEVELS+1 cycles from last beat to result.
// Accepts a beat every cycle with no backpressure; result is a one-cycle out_valid pulse.
module max_argmax_stream #(
    parameter int WIDTH      = 4,
    parameter int NUM_LANES  = 4,
    parameter int IS_SIGNED  = 0,
    parameter int BEAT_CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    max_argmax_stream_if.slave  bus
);
    localparam int LEVELS = $clog2(NUM_LANES);
    localparam int LANE_W = (LEVELS < 1) ? 1 : LEVELS;
    localparam logic [BEAT_CNT_W-1:0] CNT_MAX = '1;

    // Strictly better only: equal values never displace the incumbent.
    function automatic logic better(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic find_min);
        logic gt;
        logic lt;
        if (IS_SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return find_min ? lt : gt;
    endfunction

    logic in_frame;
    logic frame_mode;
    logic first_beat;
    logic eff_mode;

    assign first_beat = bus.in_valid & ~in_frame;
    assign eff_mode   = first_beat ? bus.mode_min : frame_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_frame   <= 1'b0;
            frame_mode <= 1'b0;
        end else if (bus.in_valid) begin
            in_frame <= ~bus.in_last;
            if (first_beat) frame_mode <= bus.mode_min;
        end
    end

    // Heap-ordered tree: node k has children 2k, 2k+1; indices >= NUM_LANES are the input lanes.
    logic [WIDTH-1:0]  leaf_v [NUM_LANES];
    logic [LANE_W-1:0] leaf_l [NUM_LANES];
    logic [WIDTH-1:0]  node_v [NUM_LANES];
    logic [LANE_W-1:0] node_l [NUM_LANES];
    logic [WIDTH-1:0]  win_v  [NUM_LANES];
    logic [LANE_W-1:0] win_l  [NUM_LANES];

    logic [LEVELS-1:0] p_vld;
    logic [LEVELS-1:0] p_first;
    logic [LEVELS-1:0] p_last;
    logic [LEVELS-1:0] p_mode;
    logic [LEVELS:0]   stage_mode;

    assign stage_mode = {p_mode, eff_mode};

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            leaf_v[i] = bus.lane_values[i*WIDTH +: WIDTH];
            leaf_l[i] = LANE_W'(i);
            win_v[i]  = '0;
            win_l[i]  = '0;
        end
        for (int k = 1; k < NUM_LANES; k++) begin
            int c;
            c = 2 * k;
            // Children of node k belong to pipeline stage LEVELS - clog2(k+1); use that beat's mode.
            if (c >= NUM_LANES) begin
                if (better(leaf_v[(c+1) % NUM_LANES], leaf_v[c % NUM_LANES],
                           stage_mode[LEVELS - $clog2(k+1)])) begin
                    win_v[k] = leaf_v[(c+1) % NUM_LANES];
                    win_l[k] = leaf_l[(c+1) % NUM_LANES];
                end else begin
                    win_v[k] = leaf_v[c % NUM_LANES];
                    win_l[k] = leaf_l[c % NUM_LANES];
                end
            end else begin
                if (better(node_v[(c+1) % NUM_LANES], node_v[c % NUM_LANES],
                           stage_mode[LEVELS - $clog2(k+1)])) begin
                    win_v[k] = node_v[(c+1) % NUM_LANES];
                    win_l[k] = node_l[(c+1) % NUM_LANES];
                end else begin
                    win_v[k] = node_v[c % NUM_LANES];
                    win_l[k] = node_l[c % NUM_LANES];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_vld   <= '0;
            p_first <= '0;
            p_last  <= '0;
            p_mode  <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                node_v[k] <= '0;
                node_l[k] <= '0;
            end
        end else begin
            p_vld   <= LEVELS'({p_vld, bus.in_valid});
            p_first <= LEVELS'({p_first, first_beat});
            p_last  <= LEVELS'({p_last, bus.in_last});
            p_mode  <= LEVELS'({p_mode, eff_mode});
            for (int k = 0; k < NUM_LANES; k++) begin
                node_v[k] <= win_v[k];
                node_l[k] <= win_l[k];
            end
        end
    end

    logic t_vld;
    logic t_first;
    logic t_last;
    logic t_mode;

    assign t_vld   = p_vld[LEVELS-1];
    assign t_first = p_first[LEVELS-1];
    assign t_last  = p_last[LEVELS-1];
    assign t_mode  = p_mode[LEVELS-1];

    logic [WIDTH-1:0]      acc_val,  n_val;
    logic [LANE_W-1:0]     acc_lane, n_lane;
    logic [BEAT_CNT_W-1:0] acc_beat, n_beat;
    logic [BEAT_CNT_W-1:0] beat_cnt, n_cnt;

    // beat_cnt holds beats already seen, which is also the index of the arriving beat.
    always_comb begin
        n_val  = acc_val;
        n_lane = acc_lane;
        n_beat = acc_beat;
        n_cnt  = beat_cnt;
        if (t_vld) begin
            if (t_first) begin
                n_val  = node_v[1];
                n_lane = node_l[1];
                n_beat = '0;
                n_cnt  = BEAT_CNT_W'(1);
            end else begin
                if (better(node_v[1], acc_val, t_mode)) begin
                    n_val  = node_v[1];
                    n_lane = node_l[1];
                    n_beat = beat_cnt;
                end
                n_cnt = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + BEAT_CNT_W'(1);
            end
        end
    end

    logic                  res_vld;
    logic [WIDTH-1:0]      res_val;
    logic [LANE_W-1:0]     res_lane;
    logic [BEAT_CNT_W-1:0] res_beat;
    logic [BEAT_CNT_W-1:0] res_beats;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_val   <= '0;
            acc_lane  <= '0;
            acc_beat  <= '0;
            beat_cnt  <= '0;
            res_vld   <= 1'b0;
            res_val   <= '0;
            res_lane  <= '0;
            res_beat  <= '0;
            res_beats <= '0;
        end else begin
            acc_val  <= n_val;
            acc_lane <= n_lane;
            acc_beat <= n_beat;
            beat_cnt <= n_cnt;
            res_vld  <= t_vld & t_last;
            if (t_vld & t_last) begin
                res_val   <= n_val;
                res_lane  <= n_lane;
                res_beat  <= n_beat;
                res_beats <= n_cnt;
            end
        end
    end

    assign bus.out_valid = res_vld;
    assign bus.out_value = res_val;
    assign bus.out_lane  = res_lane;
    assign bus.out_beat  = res_beat;
    assign bus.out_beats = res_beats;
endmodule

// File: tb/tb_max_argmax_stream.sv
// Directed frames into an unsigned and a signed instance; expected results queued per instance
// and checked by independent monitors on out_valid, including the arrival cycle.
module tb_max_argmax_stream;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_argmax_stream_if #(.WIDTH(4), .NUM_LANES(4), .BEAT_CNT_W(8)) uif ();
    max_argmax_stream_if #(.WIDTH(4), .NUM_LANES(4), .BEAT_CNT_W(8)) sif ();

    max_argmax_stream #(.WIDTH(4), .NUM_LANES(4), .IS_SIGNED(0), .BEAT_CNT_W(8)) u_uns (
        .clk(clk), .reset(reset), .bus(uif.slave)
    );
    max_argmax_stream #(.WIDTH(4), .NUM_LANES(4), .IS_SIGNED(1), .BEAT_CNT_W(8)) u_sgn (
        .clk(clk), .reset(reset), .bus(sif.slave)
    );

    typedef struct {
        int val;
        int lane;
        int beat;
        int beats;
        int cyc;
    } exp_t;

    exp_t q_u[$];
    exp_t q_s[$];

    function automatic logic [15:0] pack(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2, input logic [3:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic idle_all();
        uif.in_valid = 1'b0; uif.in_last = 1'b0; uif.mode_min = 1'b0; uif.lane_values = '0;
        sif.in_valid = 1'b0; sif.in_last = 1'b0; sif.mode_min = 1'b0; sif.lane_values = '0;
    endtask

    task automatic drive(input bit sgn, input logic [15:0] vals, input bit last, input bit mode);
        @(posedge clk);
        #1;
        idle_all();
        if (sgn) begin
            sif.in_valid = 1'b1; sif.in_last = last; sif.mode_min = mode; sif.lane_values = vals;
        end else begin
            uif.in_valid = 1'b1; uif.in_last = last; uif.mode_min = mode; uif.lane_values = vals;
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            idle_all();
        end
    endtask

    // Called right after the last beat is driven; result due three cycles later.
    task automatic expect_res(input bit sgn, input int v, input int l, input int b, input int n);
        exp_t e;
        e.val = v; e.lane = l; e.beat = b; e.beats = n; e.cyc = cyc + 3;
        if (sgn) q_s.push_back(e);
        else     q_u.push_back(e);
    endtask

    task automatic check_zero();
        check("uns_rst_valid", int'(uif.out_valid), 0);
        check("uns_rst_value", int'(uif.out_value), 0);
        check("uns_rst_lane",  int'(uif.out_lane),  0);
        check("uns_rst_beat",  int'(uif.out_beat),  0);
        check("uns_rst_beats", int'(uif.out_beats), 0);
        check("sgn_rst_valid", int'(sif.out_valid), 0);
        check("sgn_rst_value", int'(sif.out_value), 0);
    endtask

    always @(negedge clk) begin : mon_u
        exp_t e;
        if (uif.out_valid) begin
            if (q_u.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL uns_unexpected_pulse got value %0d lane %0d want no pulse (cycle %0d)",
                         uif.out_value, uif.out_lane, cyc);
            end else begin
                e = q_u.pop_front();
                check("uns_cycle", cyc, e.cyc);
                check("uns_value", int'(uif.out_value), e.val);
                check("uns_lane",  int'(uif.out_lane),  e.lane);
                check("uns_beat",  int'(uif.out_beat),  e.beat);
                check("uns_beats", int'(uif.out_beats), e.beats);
            end
        end
    end

    always @(negedge clk) begin : mon_s
        exp_t e;
        if (sif.out_valid) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sgn_unexpected_pulse got value %0d lane %0d want no pulse (cycle %0d)",
                         sif.out_value, sif.out_lane, cyc);
            end else begin
                e = q_s.pop_front();
                check("sgn_cycle", cyc, e.cyc);
                check("sgn_value", int'(sif.out_value), e.val);
                check("sgn_lane",  int'(sif.out_lane),  e.lane);
                check("sgn_beat",  int'(sif.out_beat),  e.beat);
                check("sgn_beats", int'(sif.out_beats), e.beats);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero();

        // single beat, tie between lanes 1 and 2
        drive(0, pack(3, 9, 9, 1), 1, 0);
        expect_res(0, 9, 1, 0, 1);
        gap(4);

        // three-beat max frame with a bubble; earliest beat wins the tie at 7
        drive(0, pack(2, 5, 1, 0), 0, 0);
        gap(1);
        drive(0, pack(7, 0, 7, 3), 0, 0);
        drive(0, pack(7, 7, 7, 7), 1, 0);
        expect_res(0, 7, 0, 1, 3);
        gap(4);

        // min mode latched on beat 0, mode_min drop on beat 1 ignored
        drive(0, pack(4, 2, 6, 8), 0, 1);
        drive(0, pack(1, 9, 9, 9), 1, 0);
        expect_res(0, 1, 0, 1, 2);
        gap(4);

        // signed max, signed min, then unsigned max of the same vector
        drive(1, pack(4'h8, 4'h7, 4'hF, 4'h0), 1, 0);
        expect_res(1, 7, 1, 0, 1);
        drive(1, pack(4'h8, 4'h7, 4'hF, 4'h0), 1, 1);
        expect_res(1, 8, 0, 0, 1);
        drive(0, pack(4'h8, 4'h7, 4'hF, 4'h0), 1, 0);
        expect_res(0, 15, 2, 0, 1);
        gap(4);

        // back-to-back single-beat frames
        drive(0, pack(1, 0, 0, 0), 1, 0);
        expect_res(0, 1, 0, 0, 1);
        drive(0, pack(0, 0, 0, 5), 1, 0);
        expect_res(0, 5, 3, 0, 1);
        gap(4);

        // 260-beat frame, winner at beat 258: index and count both saturate at 255
        for (int i = 0; i < 260; i++) begin
            drive(0, (i == 258) ? pack(0, 0, 4, 0) : pack(0, 0, 0, 0), i == 259, 0);
        end
        expect_res(0, 4, 2, 255, 255);
        gap(5);

        // partial frame, reset with a colliding last beat, then a fresh single-beat frame
        drive(0, pack(5, 5, 5, 5), 0, 0);
        drive(0, pack(6, 6, 6, 6), 0, 0);
        drive(0, pack(9, 9, 9, 9), 1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero();
        uif.in_valid = 1'b1; uif.in_last = 1'b1; uif.mode_min = 1'b0;
        uif.lane_values = pack(1, 1, 1, 2);
        expect_res(0, 2, 3, 0, 1);
        gap(5);

        // a last beat still inside the tree when reset hits must not produce a result
        drive(0, pack(15, 15, 15, 15), 1, 0);
        @(posedge clk);
        #1;
        idle_all();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero();
        gap(6);

        check("uns_pending_results", q_u.size(), 0);
        check("sgn_pending_results", q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
